// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the four-requester round-robin grant arbiter.
package rr_grant_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } winner_t;

    // First unmasked requester at or after ptr, wrapping mod N_REQ.
    function automatic winner_t next_winner(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic [N_REQ-1:0] mask
    );
        winner_t          w;
        logic [IDX_W-1:0] cand;
        w = '0;
        // Walk farthest-first so the closest eligible requester is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand] && !mask[cand]) begin
                w.valid = 1'b1;
                w.idx   = cand;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_decode.sv
// Enabled 2-to-4 one-hot decoder driving the shared datapath's select lines.
module decode_2to4_en
    import rr_grant_pkg::*;
(
    input  logic [IDX_W-1:0] x,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
        assign y[gi] = en && (x == IDX_W'(gi));
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin owner arbiter: a grant is held until release, requester withdrawal
// or hold expiry, with same-cycle handover to the next requester in line.
module rr_grant_arbiter
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    // "release" is a reserved word in SystemVerilog, hence this name.
    input  logic             owner_release,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       hold_reg, hold_next;
    logic             timeout_flag;
    logic             expired, withdrawn;
    logic [N_REQ-1:0] owner_mask;
    winner_t          win;

    assign owner_mask = N_REQ'(1) << idx_reg;
    assign expired    = (hold_reg == HOLD_LAST);
    assign withdrawn  = !req[idx_reg];

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        hold_next    = hold_reg;
        timeout_flag = 1'b0;
        win          = '0;
        case (state_reg)
            ST_IDLE: begin
                win = next_winner(req, ptr_reg, '0);
                if (win.valid) begin
                    idx_next   = win.idx;
                    hold_next  = '0;
                    state_next = ST_OWN;
                end
            end
            ST_OWN: begin
                if (owner_release || withdrawn || expired) begin
                    // A release or withdrawal on the last cycle is not a forced release.
                    timeout_flag = expired && !owner_release && !withdrawn;
                    ptr_next     = idx_reg + IDX_W'(1);
                    win          = next_winner(req, idx_reg + IDX_W'(1), owner_mask);
                    hold_next    = '0;
                    if (win.valid) begin
                        idx_next   = win.idx;
                        state_next = ST_OWN;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            hold_reg  <= hold_next;
        end
    end

    assign grant_valid = (state_reg == ST_OWN);
    assign grant_idx   = idx_reg;
    assign timeout     = timeout_flag && !rst;

    decode_2to4_en u_decode (
        .x  (idx_reg),
        .en (grant_valid),
        .y  (grant)
    );

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Four-requester round-robin arbiter that shares one resource (e.g. a display digit driver or shared bus) between requesters. Grant ownership is held until the owner releases or a hold-timeout expires. The registered grant index drives a 2-to-4 enable decoder to produce the one-hot grant vector. It sits between requesting experiment blocks and the shared datapath, and is the only source of that datapath's select/enable lines.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 for this revision.
- `IDX_W`, 2: width of grant index, equal to log2(`N_REQ`).
- `MAX_HOLD`, 15: maximum grant cycles before forced release; range 1..255.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request per requester; level-sensitive.
- `release`  input  1  owner finishes; sampled only while `grant_valid`=1.
- `grant_valid`  output  1  a grant is active.
- `grant_idx`  output  2  index of current owner; meaningful only when `grant_valid`=1.
- `grant`  output  4  one-hot grant, equal to decode(`grant_idx`) gated by `grant_valid`; 4'b0000 when not valid.
- `timeout`  output  1  one-cycle pulse in the cycle a forced release happens.

## Operation
- State machine has two states.
  - `IDLE`: no owner.
  - `OWN`: `grant_idx` owns the resource.
- Priority pointer `ptr` (2 bits) marks the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- `IDLE` behaviour:
  - If `req` != 0, pick the first asserted requester in search order.
  - Load `grant_idx`, clear the hold counter, and go to `OWN`.
  - Otherwise stay in `IDLE`.
- End condition in `OWN` (any one ends ownership):
  - `release`=1.
  - `req[grant_idx]`=0 (requester withdrew).
  - Hold counter reaches `MAX_HOLD`-1 (forced release). `timeout`=1 that cycle only if neither of the other two conditions holds.
- On end:
  - `ptr` ← `grant_idx`+1 mod 4.
  - Re-arbitrate in the same cycle over `req` with the current owner masked out, searching from the new `ptr`.
  - If a winner exists, go straight to `OWN` with the new index (back-to-back, no bubble); otherwise go to `IDLE`.
- No end condition: stay in `OWN` and increment the hold counter.
- Hold counter is 8 bits and never wraps, because the end condition fires first.
- A requester re-asserting immediately after losing the grant waits behind all other pending requesters.

## Timing
- Reset values: state=`IDLE`, `ptr`=0, hold counter=0, `grant_valid`=0, `grant_idx`=0, `grant`=4'b0000, `timeout`=0.
- `rst` takes priority over every other input. Asserting it mid-grant drops the grant on the next edge.
- Latency: `req` sampled on edge k in `IDLE` gives `grant_valid`=1 after edge k; visible in cycle k+1.
- `grant` is combinational from registered `grant_idx`/`grant_valid` through the decoder. There is no combinational path from `req` or `release` to `grant`.
- A grant lasts at least 1 cycle and at most `MAX_HOLD` cycles.
- Simultaneous `release` and expiry: treated as a normal release, so `timeout`=0.
- `release` while `grant_valid`=0 is ignored.

## Structure
- Package `rr_grant_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_OWN`),
  - `N_REQ`, `IDX_W`,
  - a function `next_winner(req, ptr, mask)` returning a valid flag and an index.
- Sub-module `decode_2to4_en`:
  - inputs `x[1:0]`, `en`; output `y[3:0]`;
  - `y` = one-hot of `x` when `en`=1, else 0;
  - instantiated once to generate `grant`.
- The arbiter top holds the FSM, pointer and hold counter.

## Test plan
- Reset, then `req`=4'b0101 held: grants go idx 0, then idx 2 after `release`, then idx 0 again. Each `grant` is one-hot (4'b0001, 4'b0100) and each handover is back-to-back with no idle cycle.
- `req`=4'b1111 with `release` pulsed every 3 cycles: grant order 0,1,2,3,0. `ptr` after each handover is 1,2,3,0.
- `MAX_HOLD`=4 and `req`=4'b0011 held with no `release`:
  - idx 0 owns exactly 4 cycles;
  - `timeout` pulses once;
  - idx 1 owns the next cycle.
- During idx 2 ownership, `req[2]` drops and `req`=4'b0000: `grant_valid`=0 next cycle, `timeout`=0, `ptr`=3.
- `rst` asserted mid-grant (idx 3, cycle 2 of hold): next cycle `grant`=4'b0000 and `ptr`=0. With `req`=4'b1000 still high, idx 3 is re-granted one cycle after `rst` falls.
- `release` and hold expiry coincide with `MAX_HOLD`=2: `timeout`=0, and the handover otherwise matches a normal release.
